// File: rtl/ldl_ram_rd_pkg.sv
// ldl_ram_rd_pkg
//   Shared types and constants for the RAM burst reader.
//   rd_state_e    : reader FSM states (IDLE / RUN / DRAIN)
//   RD_BUF_DEPTH  : output buffer depth; also the maximum number of reads
//                   that may be outstanding at once
//   buf_ptr_inc() : modulo-RD_BUF_DEPTH pointer increment
package ldl_ram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int RD_BUF_DEPTH = 3;
    localparam int RD_CNT_W     = 2;   // wide enough to hold 0..RD_BUF_DEPTH

    function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
        return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/ldl_rd_skid_buf.sv
// ldl_rd_skid_buf
//   3-entry FIFO holding RAM read data (plus last tag) until the stream
//   consumer accepts it.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : empties the buffer (takes priority over a same-cycle write)
//   wr_en/wr_data : push
//   rd_en     : pop the head entry (ignored when empty)
//   rd_data   : head entry
//   count     : current occupancy, 0..RD_BUF_DEPTH
module ldl_rd_skid_buf
    import ldl_ram_rd_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [W-1:0]        wr_data,
    input  logic                rd_en,
    output logic [W-1:0]        rd_data,
    output logic [RD_CNT_W-1:0] count
);

    logic [W-1:0]        mem_q [RD_BUF_DEPTH];
    logic [W-1:0]        mem_d [RD_BUF_DEPTH];
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [RD_CNT_W-1:0] count_q, count_d;
    logic                do_rd;

    assign do_rd   = rd_en && (count_q != '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = buf_ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_d = buf_ptr_inc(rd_ptr_q);
            end
            count_d = count_q + RD_CNT_W'(wr_en) - RD_CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ldl_ram_burst_reader.sv
// ldl_ram_burst_reader
//   Reads one contiguous burst (wrapping at the top of memory) from a
//   1-cycle-latency RAM read port and presents it as a valid/ready stream.
//   clk, rst            : clock, asynchronous active-high reset
//   start/start_addr/len_m1 : burst command, sampled only in IDLE
//   busy, done          : burst in progress / one-cycle completion pulse
//   reb, addrb, doutb   : RAM read port
//   m_valid/m_ready/m_data/m_last : output stream
//   abort               : present only when LDL_RAM_RD_ABORT_EN is defined;
//                         cancels the current burst and flushes the buffer
module ldl_ram_burst_reader
    import ldl_ram_rd_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH-1:0] len_m1,
`ifdef LDL_RAM_RD_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              reb,
    output logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    rd_state_e           state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [AWIDTH-1:0]   rem_q, rem_d;
    logic                infl_q, infl_d;           // read issued last cycle
    logic                infl_last_q, infl_last_d; // ... and it was the last one
    logic                done_q, done_d;
    logic [RD_CNT_W-1:0] buf_cnt;
    logic [DWIDTH:0]     buf_head;
    logic [2:0]          credit;
    logic                issue, pop, abort_w;

`ifdef LDL_RAM_RD_ABORT_EN
    assign abort_w = abort && (state_q != ST_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // Credit uses only registered state, keeping m_ready off the read path.
    assign credit = {1'b0, buf_cnt} + {2'b0, infl_q};
    assign issue  = (state_q == ST_RUN) && (credit < 3'(RD_BUF_DEPTH)) && !abort_w;
    assign pop    = m_valid && m_ready;

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign reb     = issue;
    assign addrb   = addr_q;
    assign m_valid = (buf_cnt != '0);
    assign m_data  = m_valid ? buf_head[DWIDTH-1:0] : '0;
    assign m_last  = m_valid && buf_head[DWIDTH];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_last_d = issue && (rem_q == '0);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = start_addr;
                    rem_d   = len_m1;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that hands off the final word so the FSM
                // is already IDLE (and can take a new start) while done is high.
                if (!infl_q && ((buf_cnt == '0) || ((buf_cnt == RD_CNT_W'(1)) && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_w) begin
            state_d     = ST_IDLE;
            infl_d      = 1'b0;
            infl_last_d = 1'b0;
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    // An in-flight word arriving during abort is dropped by the flush.
    ldl_rd_skid_buf #(.W(DWIDTH + 1)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_w),
        .wr_en   (infl_q),
        .wr_data ({infl_last_q, doutb}),
        .rd_en   (pop),
        .rd_data (buf_head),
        .count   (buf_cnt)
    );

endmodule

// File: tb/tb_ldl_ram_burst_reader.sv
module tb_ldl_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] start_addr = '0;
    logic [3:0] len_m1 = '0;
    logic       abort = 1'b0;
    logic       busy, done, reb, m_valid, m_last;
    logic [3:0] addrb;
    logic [7:0] doutb = '0;
    logic [7:0] m_data;
    logic       m_ready = 1'b1;

    logic [7:0] mem [16];
    logic [8:0] exp_q [$];
    logic [3:0] addr_log [$];
    int         hs_cyc [$];
    int         checks = 0, errors = 0;
    int         cyc = 0, issued = 0, popped = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // RAM read port model: 1-cycle latency
    always @(posedge clk) if (reb) doutb <= mem[addrb];

    ldl_ram_burst_reader #(.DWIDTH(8), .AWIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len_m1(len_m1),
`ifdef LDL_RAM_RD_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .reb(reb), .addrb(addrb), .doutb(doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor / scoreboard, sampling on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (reb) begin
                chk("outstanding_lt3_at_reb", 32'(issued - popped < 3), 1);
                addr_log.push_back(addrb);
                issued++;
            end
            if (stall_prev) chk("stable_while_stalled", {23'd0, m_last, m_data}, 32'(stall_val));
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                popped++;
                if (exp_q.size() == 0) chk("spurious_word", {23'd0, m_last, m_data}, 32'h1ff);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e[7:0]));
                    chk("m_last", 32'(m_last), 32'(e[8]));
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_val  = {m_last, m_data};
        end else stall_prev = 1'b0;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issue a burst and queue its expected words; returns the cycle count
    // at which start was raised (edge E0 is the next one).
    task automatic launch(input logic [3:0] a, input logic [3:0] l, output int c);
        logic [3:0] ad;
        for (int k = 0; k <= int'(l); k++) begin
            ad = a + 4'(k);
            exp_q.push_back({(k == int'(l)), mem[ad]});
        end
        start_addr = a; len_m1 = l; start = 1'b1;
        c = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc; break; end
        end
        chk("done_seen", 32'(dc >= 0), 1);
    endtask

    task automatic wait_popped(input int n, input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (popped >= n) begin ok = 1; break; end
        end
        chk("wait_popped", ok, 1);
    endtask

    initial begin
        int c, dc, ok;
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        int c, dc, ok;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_reb", 32'(reb), 0);
        chk("rst_addrb", 32'(addrb), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        rst = 1'b0;
        step();

        // 1: basic burst 2..5, timing
        hs_cyc.delete();
        launch(4'd2, 4'd3, c);
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_reb_c1", 32'(reb), 1);
        chk("t1_addrb_c1", 32'(addrb), 2);
        wait_done(40, dc);
        chk("t1_done_cycle", dc, c + 7);
        chk("t1_busy_at_done", 32'(busy), 0);
        chk("t1_hs_count", hs_cyc.size(), 4);
        for (int i = 0; i < 4 && i < hs_cyc.size(); i++) chk("t1_hs_cycle", hs_cyc[i], c + 3 + i);
        step();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_drained", exp_q.size(), 0);

        // 2: wrap at the top of memory
        addr_log.delete();
        launch(4'd14, 4'd3, c);
        wait_done(40, dc);
        chk("t2_addr_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("t2_addr0", 32'(addr_log[0]), 14);
            chk("t2_addr1", 32'(addr_log[1]), 15);
            chk("t2_addr2", 32'(addr_log[2]), 0);
            chk("t2_addr3", 32'(addr_log[3]), 1);
        end
        chk("t2_drained", exp_q.size(), 0);
        step();

        // 3: stall mid-burst
        issued = 0; popped = 0;
        launch(4'd4, 4'd7, c);
        wait_popped(2, 40);
        step();
        m_ready = 1'b0;
        repeat (10) step();
        chk("t3_outstanding", issued - popped, 3);
        chk("t3_no_reb_stalled", 32'(reb), 0);
        m_ready = 1'b1;
        wait_done(60, dc);
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_issued", issued, 8);
        step();

        // 4: full depth, m_ready toggling, stray start ignored
        ok = 0;
        launch(4'd0, 4'd15, c);
        for (int i = 0; i < 200; i++) begin
            m_ready = ~m_ready;
            start = (i == 5);
            start_addr = 4'd9; len_m1 = 4'd0;
            @(negedge clk);
            if (done) begin ok = 1; break; end
            step();
        end
        start = 1'b0; m_ready = 1'b1;
        chk("t4_done_seen", ok, 1);
        chk("t4_drained", exp_q.size(), 0);
        step();
        chk("t4_idle_after", 32'(busy), 0);

        // 5: reset mid-burst, then single-word burst
        issued = 0; popped = 0;
        launch(4'd0, 4'd7, c);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (issued >= 2) begin ok = 1; break; end
        end
        chk("t5_two_reads", ok, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_reb", 32'(reb), 0);
        chk("t5_addrb", 32'(addrb), 0);
        chk("t5_m_valid", 32'(m_valid), 0);
        chk("t5_m_data", 32'(m_data), 0);
        chk("t5_m_last", 32'(m_last), 0);
        exp_q.delete(); issued = 0; popped = 0;
        step(); step();
        rst = 1'b0;
        step();
        launch(4'd0, 4'd0, c);
        wait_done(20, dc);
        chk("t5_single_done_cycle", dc, c + 4);
        chk("t5_single_pops", popped, 1);
        chk("t5_drained", exp_q.size(), 0);
        step();

`ifdef LDL_RAM_RD_ABORT_EN
        // 6: abort after two words accepted
        issued = 0; popped = 0;
        launch(4'd0, 4'd7, c);
        wait_popped(2, 40);
        step();
        abort = 1'b1; m_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("t6_m_valid", 32'(m_valid), 0);
        chk("t6_done", 32'(done), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_popped", popped, 2);
        exp_q.delete();
        repeat (3) begin
            step();
            chk("t6_quiet_valid", 32'(m_valid), 0);
        end
        m_ready = 1'b1;
        launch(4'd5, 4'd2, c);
        wait_done(30, dc);
        chk("t6_next_done_cycle", dc, c + 6);
        chk("t6_drained", exp_q.size(), 0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldl_ram_burst_reader.md
# ldl_ram_burst_reader

- Read-side engine for the library's simple 2-port RAM: drives the RAM read port (`reb`/`addrb`), absorbs its fixed 1-cycle read latency and presents the words as a valid/ready stream.
- A host command (`start`, base address, length) reads one contiguous burst, wrapping at the top of memory; the last word is flagged.
- Sits beside the RAM's write port in packet buffers and frame stores; no read-side pacing logic is needed downstream.

## Interface
- `DWIDTH`, 8, data width; must match the RAM.
- `AWIDTH`, 4, address width; RAM depth is `1<<AWIDTH`.
- `clk`  in  1  single clock; RAM read port and this block share it.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `start_addr`  in  AWIDTH  first word address.
- `len_m1`  in  AWIDTH  burst length minus one (1..DEPTH words).
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last word has been handed off.
- `reb`  out  1  RAM read enable.
- `addrb`  out  AWIDTH  RAM read address.
- `doutb`  in  DWIDTH  RAM read data, valid the cycle after `reb`.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DWIDTH  stream data.
- `m_last`  out  1  marks the final word of the burst.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start`. Latch `start_addr` into the address counter and `len_m1` into the remaining-count register.
  - RUN -> DRAIN in the cycle the last read is issued.
  - DRAIN -> IDLE when the output buffer is empty and no read is in flight. `done` pulses in that same transition cycle.
- Read issue, RUN only:
  - `reb`=1 when credit = buffer occupancy + in-flight reads < 3.
  - Credit is computed from registered state only, so there is no combinational path from `m_ready` to `reb` or `addrb`.
- After each issue:
  - `addrb` increments modulo DEPTH; DEPTH-1 wraps to 0.
  - The remaining count decrements.
  - The issue made with remaining count == 0 is the last read.
- The output buffer is a 3-entry FIFO.
  - It is written with `doutb` (plus the last tag) in the cycle after each `reb`.
  - It is popped on `m_valid && m_ready`.
  - It never overflows, by construction of the credit rule.
- `m_last`=1 only on the word from the last read.
- `start` while `busy` is ignored; no queueing.
- Once `m_valid` is asserted, `m_data` and `m_last` hold stable until accepted.
- Reset, including mid-burst: all state and buffer contents are cleared and in-flight data is discarded.
  - Reset values: `busy`=0, `done`=0, `reb`=0, `addrb`=0, `m_valid`=0, `m_data`=0, `m_last`=0; FSM in IDLE.

## Timing
- `start` is sampled at edge E0.
  - `busy`=1 and the first `reb` are in cycle 1.
  - `doutb` is valid in cycle 2.
  - `m_valid`=1 from cycle 3.
- Throughput with `m_ready` held high: one word per cycle, with no bubbles after the first word.
- `m_ready` low: at most 3 reads are outstanding, after which `reb` stays low until a pop.
- `done` pulses one cycle after the `m_last` handshake; `busy` falls in the same cycle `done` is high.
- Back-to-back bursts: the earliest next `start` is accepted in the cycle `done` is high (FSM already IDLE). Minimum gap: 3 cycles of idle stream between bursts.

## Configuration
- Macro: `LDL_RAM_RD_ABORT_EN`.
- Defined: adds input `abort` (1 bit).
  - `abort` high while `busy`: stop issuing, flush the buffer, discard any in-flight word, return to IDLE.
  - `m_valid`=0 and `done`=1 on the next cycle. No `m_last` is emitted for the aborted burst.
- Undefined: the port is absent and bursts always run to completion.

## Structure
- Package `ldl_ram_rd_pkg`: FSM state enum (IDLE/RUN/DRAIN) and the buffer-depth constant `RD_BUF_DEPTH = 3`.
- One sub-module, `ldl_rd_skid_buf`: 3-entry FIFO, width DWIDTH+1, exposing its occupancy count.

## Test plan
- RAM preloaded with mem[i]=i, `start_addr`=2, `len_m1`=3, `m_ready`=1 -> data 2,3,4,5 on consecutive cycles from cycle 3; `m_last` on 5; `done` the next cycle.
- AWIDTH=4, `start_addr`=14, `len_m1`=3 -> addresses 14,15,0,1; data 14,15,0,1.
- `m_ready`=0 for 10 cycles mid-burst -> exactly 3 reads outstanding, no `reb` while stalled, no lost or duplicated word, `m_data` stable while stalled.
- `len_m1`=15 (full DEPTH) with `m_ready` toggling every cycle -> all 16 words in order; a `start` pulse during the burst is ignored.
- `rst` asserted in the cycle after the second `reb` -> all outputs return to reset values immediately. A following burst with `start_addr`=0, `len_m1`=0 returns the single word 0 with `m_last`=1.
- With `LDL_RAM_RD_ABORT_EN`: `abort` after 2 of 8 words accepted -> `m_valid`=0 next cycle, `done`=1, `m_last` never seen; the next burst starts clean.
